// File: rtl/ide_disk_emu.sv
// Clocked ATA/IDE PIO disk emulator: taskfile registers, one-sector buffer, multi-sector READ/WRITE via a req/ack store port.
// Strobe actions land 3 clk after the pin falls; store requests are held until ack and may run back-to-back.
module ide_disk_emu #(
    parameter int DATA_W       = 16,
    parameter int SECTOR_WORDS = 256,
    parameter int LBA_W        = 28,
    parameter int MEM_AW       = 36
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] ide_data_in,
    output logic [DATA_W-1:0] ide_data_out,
    input  logic              ide_dior,
    input  logic              ide_diow,
    input  logic [1:0]        ide_cs,
    input  logic [2:0]        ide_da,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_we,
    output logic              mem_req,
    input  logic              mem_ack
);
    localparam int PW = $clog2(SECTOR_WORDS);
    localparam logic [PW-1:0] PTR_LAST = PW'(SECTOR_WORDS - 1);
    localparam logic [7:0] ST_READY = 8'h50;
    localparam logic [7:0] ST_BUSY  = 8'hD0;
    localparam logic [7:0] ST_DRQ   = 8'h58;
    localparam logic [7:0] ST_ERR   = 8'h51;

    typedef enum logic [2:0] {S_IDLE, S_RD_FETCH, S_RD_XFER, S_WR_XFER, S_WR_FLUSH} state_t;

    state_t            state_q, state_d;
    logic [7:0]        status_q, status_d, error_q, error_d;
    logic [7:0]        seccnt_q, seccnt_d, secnum_q, secnum_d;
    logic [7:0]        cyllow_q, cyllow_d, cylhigh_q, cylhigh_d, drvhead_q, drvhead_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [LBA_W-1:0]  lba_q, lba_d, lba_start;
    logic [8:0]        rem_q, rem_d;
    logic [DATA_W-1:0] data_out_q, data_out_d, rd_val, sbuf_wd;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic              sbuf_we, srst;
    logic [DATA_W-1:0] sbuf_q [SECTOR_WORDS];

    logic dior_s1_q, dior_s2_q, dior_e_q, diow_s1_q, diow_s2_q, diow_e_q;
    logic dior_fall, dior_rise, diow_fall, last_word;
    logic [4:0]  addr;
    logic [27:0] lba_raw;

    assign dior_fall = dior_e_q & ~dior_s2_q;
    assign dior_rise = ~dior_e_q & dior_s2_q;
    assign diow_fall = diow_e_q & ~diow_s2_q;
    assign addr      = {ide_cs, ide_da};
    assign last_word = (ptr_q == PTR_LAST);
    assign lba_raw   = {drvhead_q[3:0], cylhigh_q, cyllow_q, secnum_q};
    assign lba_start = LBA_W'(lba_raw);

    assign ide_data_out = data_out_q;
    assign mem_addr     = MEM_AW'({lba_q, ptr_q});
    assign mem_wdata    = sbuf_q[ptr_q];
    assign mem_we       = mem_we_q;
    assign mem_req      = mem_req_q;

    always_comb begin
        state_d = state_q;     status_d = status_q;   error_d = error_q;
        seccnt_d = seccnt_q;   secnum_d = secnum_q;   cyllow_d = cyllow_q;
        cylhigh_d = cylhigh_q; drvhead_d = drvhead_q;
        ptr_d = ptr_q;         lba_d = lba_q;         rem_d = rem_q;
        data_out_d = data_out_q;
        mem_req_d = mem_req_q; mem_we_d = mem_we_q;
        sbuf_we = 1'b0;        sbuf_wd = ide_data_in;
        rd_val = '0;           srst = 1'b0;

        // Store side: one word per ack, independent of any strobe this cycle.
        if (mem_req_q && mem_ack) begin
            ptr_d = ptr_q + PW'(1);
            if (state_q == S_RD_FETCH) begin
                sbuf_we = 1'b1;
                sbuf_wd = mem_rdata;
            end
            if (last_word) begin
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
                ptr_d     = '0;
                if (state_q == S_RD_FETCH) begin
                    status_d = ST_DRQ;
                    state_d  = S_RD_XFER;
                end else begin
                    lba_d = lba_q + LBA_W'(1);
                    rem_d = rem_q - 9'd1;
                    status_d = (rem_q != 9'd1) ? ST_DRQ : ST_READY;
                    state_d  = (rem_q != 9'd1) ? S_WR_XFER : S_IDLE;
                end
            end
        end

        if (dior_fall) begin
            case (addr)
                5'h10: if (state_q == S_RD_XFER) begin
                    rd_val = sbuf_q[ptr_q];
                    ptr_d  = ptr_q + PW'(1);
                    if (last_word) begin
                        rem_d = rem_q - 9'd1;
                        lba_d = lba_q + LBA_W'(1);
                        if (rem_q != 9'd1) begin
                            status_d  = ST_BUSY;
                            state_d   = S_RD_FETCH;
                            mem_req_d = 1'b1;
                        end else begin
                            status_d = ST_READY;
                            state_d  = S_IDLE;
                        end
                    end
                end
                5'h11: rd_val = DATA_W'(error_q);
                5'h12: rd_val = DATA_W'(seccnt_q);
                5'h13: rd_val = DATA_W'(secnum_q);
                5'h14: rd_val = DATA_W'(cyllow_q);
                5'h15: rd_val = DATA_W'(cylhigh_q);
                5'h16: rd_val = DATA_W'(drvhead_q);
                5'h17, 5'h0e: rd_val = DATA_W'(status_q);
                default: rd_val = '0;
            endcase
            data_out_d = rd_val;
        end else if (dior_rise) begin
            data_out_d = '0;
        end

        if (diow_fall) begin
            case (addr)
                5'h10: if (state_q == S_WR_XFER) begin
                    sbuf_we = 1'b1;
                    sbuf_wd = ide_data_in;
                    ptr_d   = ptr_q + PW'(1);
                    if (last_word) begin
                        ptr_d     = '0;
                        status_d  = ST_BUSY;
                        state_d   = S_WR_FLUSH;
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b1;
                    end
                end
                5'h12: if (!status_q[7]) seccnt_d  = ide_data_in[7:0];
                5'h13: if (!status_q[7]) secnum_d  = ide_data_in[7:0];
                5'h14: if (!status_q[7]) cyllow_d  = ide_data_in[7:0];
                5'h15: if (!status_q[7]) cylhigh_d = ide_data_in[7:0];
                5'h16: if (!status_q[7]) drvhead_d = ide_data_in[7:0];
                5'h17: if (state_q == S_IDLE) begin
                    lba_d = lba_start;
                    rem_d = (seccnt_q == 8'd0) ? 9'd256 : {1'b0, seccnt_q};
                    ptr_d = '0;
                    if (ide_data_in[7:0] == 8'h20) begin
                        error_d = 8'h00;  status_d = ST_BUSY;
                        state_d = S_RD_FETCH;
                        mem_req_d = 1'b1; mem_we_d = 1'b0;
                    end else if (ide_data_in[7:0] == 8'h30) begin
                        error_d = 8'h00;  status_d = ST_DRQ;
                        state_d = S_WR_XFER;
                    end else begin
                        error_d = 8'h04;  status_d = ST_ERR;
                    end
                end
                5'h1e: srst = ide_data_in[2];
                default: ;
            endcase
        end

        // Soft reset overrides everything, including an ack landing this cycle.
        if (srst) begin
            state_d = S_IDLE;  status_d = ST_READY; error_d = 8'h00;
            mem_req_d = 1'b0;  mem_we_d = 1'b0;     ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dior_s1_q <= 1'b1; dior_s2_q <= 1'b1; dior_e_q <= 1'b1;
            diow_s1_q <= 1'b1; diow_s2_q <= 1'b1; diow_e_q <= 1'b1;
            state_q <= S_IDLE;  status_q <= ST_READY; error_q <= 8'h00;
            seccnt_q <= 8'h00;  secnum_q <= 8'h00;    cyllow_q <= 8'h00;
            cylhigh_q <= 8'h00; drvhead_q <= 8'h00;
            ptr_q <= '0; lba_q <= '0; rem_q <= '0;
            data_out_q <= '0; mem_req_q <= 1'b0; mem_we_q <= 1'b0;
        end else begin
            dior_s1_q <= ide_dior; dior_s2_q <= dior_s1_q; dior_e_q <= dior_s2_q;
            diow_s1_q <= ide_diow; diow_s2_q <= diow_s1_q; diow_e_q <= diow_s2_q;
            state_q <= state_d;     status_q <= status_d;   error_q <= error_d;
            seccnt_q <= seccnt_d;   secnum_q <= secnum_d;   cyllow_q <= cyllow_d;
            cylhigh_q <= cylhigh_d; drvhead_q <= drvhead_d;
            ptr_q <= ptr_d; lba_q <= lba_d; rem_q <= rem_d;
            data_out_q <= data_out_d; mem_req_q <= mem_req_d; mem_we_q <= mem_we_d;
        end
    end

    always_ff @(posedge clk) begin
        if (sbuf_we) sbuf_q[ptr_q] <= sbuf_wd;
    end
endmodule

// File: tb/tb_ide_disk_emu.sv
// Directed bench for ide_disk_emu: register table, multi-sector read/write, abort, soft reset, LBA wrap.
module tb_ide_disk_emu;
    localparam int SW  = 16;
    localparam int MAW = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [15:0]       ide_data_in, ide_data_out;
    logic              ide_dior, ide_diow;
    logic [1:0]        ide_cs;
    logic [2:0]        ide_da;
    logic [MAW-1:0]    mem_addr;
    logic [15:0]       mem_wdata, mem_rdata;
    logic              mem_we, mem_req, mem_ack;

    ide_disk_emu #(.DATA_W(16), .SECTOR_WORDS(SW), .LBA_W(28), .MEM_AW(MAW)) dut (
        .clk(clk), .reset(reset), .ide_data_in(ide_data_in), .ide_data_out(ide_data_out),
        .ide_dior(ide_dior), .ide_diow(ide_diow), .ide_cs(ide_cs), .ide_da(ide_da),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_req(mem_req), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] store [logic [MAW-1:0]];
    logic [MAW-1:0] ack_addr_q [$];
    logic ack_we_q [$];
    logic [15:0] ack_wd_q [$];
    logic ack_en = 1'b0;
    logic stray_ack = 1'b0;
    logic [15:0] rd_idle;
    logic post_wr_req;

    function automatic logic [15:0] store_rd(input logic [MAW-1:0] a);
        if (store.exists(a)) return store[a];
        return a[15:0] ^ a[31:16] ^ 16'h5A5A;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic host_rd(input logic [4:0] a, output logic [15:0] v);
        @(negedge clk);
        {ide_cs, ide_da} = a;
        ide_dior = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        v = ide_data_out;
        ide_dior = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rd_idle = ide_data_out;
    endtask

    task automatic host_wr(input logic [4:0] a, input logic [15:0] d);
        @(negedge clk);
        {ide_cs, ide_da} = a;
        ide_data_in = d;
        ide_diow = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        post_wr_req = mem_req;
        ide_diow = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic rd_chk(input string nm, input logic [4:0] a, input logic [15:0] exp);
        logic [15:0] v;
        host_rd(a, v);
        chk(nm, {16'h0, v}, {16'h0, exp});
    endtask

    task automatic wait_fetch(input string nm, input int target);
        int t = 0;
        while ((ack_addr_q.size() < target || mem_req) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk(nm, {31'h0, (t < 5000)}, 32'h1);
    endtask

    // Backing store: acks two cycles in three while enabled, logs every transfer.
    initial begin
        int cyc = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mem_req && ack_en && (cyc % 3 != 2)) begin
                mem_ack = 1'b1;
                mem_rdata = store_rd(mem_addr);
                ack_addr_q.push_back(mem_addr);
                ack_we_q.push_back(mem_we);
                ack_wd_q.push_back(mem_wdata);
                if (mem_we) store[mem_addr] = mem_wdata;
            end else begin
                mem_ack = stray_ack;
                mem_rdata = 16'hDEAD;
            end
        end
    end

    typedef struct {
        logic        wr;
        logic [4:0]  a;
        logic [15:0] d;
        logic [15:0] exp;
    } vec_t;
    localparam int NV = 24;
    vec_t vt [NV] = '{
        '{1'b0, 5'h17, 16'h0000, 16'h0050}, '{1'b0, 5'h11, 16'h0000, 16'h0000},
        '{1'b0, 5'h0e, 16'h0000, 16'h0050}, '{1'b0, 5'h12, 16'h0000, 16'h0000},
        '{1'b0, 5'h16, 16'h0000, 16'h0000}, '{1'b1, 5'h12, 16'h1234, 16'h0000},
        '{1'b0, 5'h12, 16'h0000, 16'h0034}, '{1'b1, 5'h13, 16'h00ab, 16'h0000},
        '{1'b0, 5'h13, 16'h0000, 16'h00ab}, '{1'b1, 5'h14, 16'h00cd, 16'h0000},
        '{1'b0, 5'h14, 16'h0000, 16'h00cd}, '{1'b1, 5'h15, 16'h00ef, 16'h0000},
        '{1'b0, 5'h15, 16'h0000, 16'h00ef}, '{1'b1, 5'h16, 16'h00e7, 16'h0000},
        '{1'b0, 5'h16, 16'h0000, 16'h00e7}, '{1'b0, 5'h10, 16'h0000, 16'h0000},
        '{1'b0, 5'h05, 16'h0000, 16'h0000}, '{1'b0, 5'h1e, 16'h0000, 16'h0000},
        '{1'b1, 5'h11, 16'h00ff, 16'h0000}, '{1'b0, 5'h11, 16'h0000, 16'h0000},
        '{1'b1, 5'h17, 16'h00ec, 16'h0000}, '{1'b0, 5'h17, 16'h0000, 16'h0051},
        '{1'b0, 5'h11, 16'h0000, 16'h0004}, '{1'b0, 5'h0e, 16'h0000, 16'h0051}
    };

    initial begin
        int base;
        int n_before;
        logic [27:0] lba;
        reset = 1'b1;
        ide_dior = 1'b1;
        ide_diow = 1'b1;
        ide_cs = 2'b00;
        ide_da = 3'b000;
        ide_data_in = '0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_data_out", {16'h0, ide_data_out}, 32'h0);

        for (int i = 0; i < NV; i++) begin
            if (vt[i].wr) host_wr(vt[i].a, vt[i].d);
            else rd_chk($sformatf("vec%0d", i), vt[i].a, vt[i].exp);
        end

        // Single-sector READ at LBA 5, which also clears the earlier abort.
        host_wr(5'h13, 16'h0005);
        host_wr(5'h14, 16'h0000);
        host_wr(5'h15, 16'h0000);
        host_wr(5'h16, 16'h00e0);
        host_wr(5'h12, 16'h0001);
        for (int k = 0; k < SW; k++) store[MAW'(5 * SW + k)] = 16'(k);
        ack_addr_q.delete(); ack_we_q.delete(); ack_wd_q.delete();
        ack_en = 1'b0;
        host_wr(5'h17, 16'h0020);
        rd_chk("rd_fetch_status", 5'h17, 16'h00d0);
        rd_chk("err_cleared", 5'h11, 16'h0000);
        rd_chk("rd_fetch_alt", 5'h0e, 16'h00d0);
        host_wr(5'h13, 16'h0077);
        ack_en = 1'b1;
        wait_fetch("rd_fetch_done", SW);
        for (int k = 0; k < SW; k++) begin
            chk($sformatf("rd_addr%0d", k), ack_addr_q[k], 32'(5 * SW + k));
            chk($sformatf("rd_we%0d", k), {31'h0, ack_we_q[k]}, 32'h0);
        end
        rd_chk("rd_drq", 5'h17, 16'h0058);
        for (int k = 0; k < SW; k++) rd_chk($sformatf("rd_data%0d", k), 5'h10, 16'(k));
        chk("data_out_after_rise", {16'h0, rd_idle}, 32'h0);
        rd_chk("rd_done_status", 5'h17, 16'h0050);
        rd_chk("tf_bsy_ignored", 5'h13, 16'h0005);
        rd_chk("data_idle", 5'h10, 16'h0000);

        // Two-sector WRITE at LBA 9.
        host_wr(5'h13, 16'h0009);
        host_wr(5'h12, 16'h0002);
        ack_addr_q.delete(); ack_we_q.delete(); ack_wd_q.delete();
        ack_en = 1'b0;
        host_wr(5'h17, 16'h0030);
        rd_chk("wr_drq", 5'h17, 16'h0058);
        host_wr(5'h17, 16'h00ec);
        rd_chk("cmd_busy_ignored", 5'h17, 16'h0058);
        rd_chk("cmd_busy_err", 5'h11, 16'h0000);
        for (int i = 0; i < SW; i++) host_wr(5'h10, 16'(16'hA000 + i));
        rd_chk("wr_flush1_status", 5'h17, 16'h00d0);
        ack_en = 1'b1;
        wait_fetch("wr_flush1_done", SW);
        rd_chk("wr_between", 5'h17, 16'h0058);
        ack_en = 1'b0;
        for (int i = 0; i < SW; i++) host_wr(5'h10, 16'(16'hA000 + SW + i));
        rd_chk("wr_flush2_status", 5'h17, 16'h00d0);
        ack_en = 1'b1;
        wait_fetch("wr_flush2_done", 2 * SW);
        rd_chk("wr_done_status", 5'h17, 16'h0050);
        for (int j = 0; j < 2 * SW; j++) begin
            chk($sformatf("wr_addr%0d", j), ack_addr_q[j], 32'(9 * SW + j));
            chk($sformatf("wr_we%0d", j), {31'h0, ack_we_q[j]}, 32'h1);
            chk($sformatf("wr_dat%0d", j), {16'h0, ack_wd_q[j]}, 32'(16'hA000 + j));
        end

        // Soft reset in the middle of a fetch with a request outstanding.
        host_wr(5'h13, 16'h0005);
        host_wr(5'h12, 16'h0001);
        ack_addr_q.delete(); ack_we_q.delete(); ack_wd_q.delete();
        ack_en = 1'b1;
        host_wr(5'h17, 16'h0020);
        ack_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("srst_req_before", {31'h0, mem_req}, 32'h1);
        chk("srst_mid_fetch", {31'h0, (ack_addr_q.size() < SW)}, 32'h1);
        host_wr(5'h1e, 16'h0004);
        chk("srst_req_drop", {31'h0, post_wr_req}, 32'h0);
        n_before = ack_addr_q.size();
        stray_ack = 1'b1;
        repeat (3) @(negedge clk);
        stray_ack = 1'b0;
        chk("stray_ack_req", {31'h0, mem_req}, 32'h0);
        host_wr(5'h1e, 16'h0000);
        rd_chk("srst_status", 5'h17, 16'h0050);
        rd_chk("srst_error", 5'h11, 16'h0000);
        rd_chk("srst_data", 5'h10, 16'h0000);
        chk("srst_no_more_acks", 32'(ack_addr_q.size()), 32'(n_before));

        // seccnt=0 READ from the last LBA: 256 sectors, wrapping to LBA 0.
        host_wr(5'h13, 16'h00ff);
        host_wr(5'h14, 16'h00ff);
        host_wr(5'h15, 16'h00ff);
        host_wr(5'h16, 16'h00ef);
        host_wr(5'h12, 16'h0000);
        ack_addr_q.delete(); ack_we_q.delete(); ack_wd_q.delete();
        ack_en = 1'b1;
        host_wr(5'h17, 16'h0020);
        for (int s = 0; s < 256; s++) begin
            lba = 28'hFFFFFFF + 28'(s);
            base = s * SW;
            wait_fetch($sformatf("wrap_fetch%0d", s), base + SW);
            if (s < 2) begin
                for (int k = 0; k < SW; k++)
                    chk($sformatf("wrap_addr%0d_%0d", s, k), ack_addr_q[base + k],
                        32'(lba) * SW + 32'(k));
            end else begin
                chk($sformatf("wrap_addr%0d", s), ack_addr_q[base], 32'(lba) * SW);
            end
            if (s == 0) rd_chk("wrap_drq", 5'h17, 16'h0058);
            for (int k = 0; k < SW; k++)
                rd_chk($sformatf("wrap_data%0d_%0d", s, k), 5'h10,
                       store_rd(MAW'(32'(lba) * SW + 32'(k))));
        end
        rd_chk("wrap_done_status", 5'h17, 16'h0050);
        chk("wrap_total_acks", 32'(ack_addr_q.size()), 32'(256 * SW));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ide_disk_emu.md
Name: ide_disk_emu

Overview:
- Synthesisable, clocked ATA/IDE PIO disk emulator. It is the clocked successor to the simulation-only disk model.
- Sits on the IDE controller's bus pins in both the FPGA build and the bench.
- Implements the taskfile registers and multi-sector READ/WRITE with a one-sector buffer, plus abort/error and soft-reset behaviour.
- Sector data is kept in an external backing store reached through a req/ack word port.

Parameters:
- DATA_W, 16, IDE data bus width.
- SECTOR_WORDS, 256, words per sector. Must be a power of two.
- LBA_W, 28, LBA width.
- MEM_AW, 36, backing-store word address width. Must be ≥ LBA_W + log2(SECTOR_WORDS).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- ide_data_in  in  DATA_W  host write data.
- ide_data_out  out  DATA_W  device read data.
- ide_dior  in  1  read strobe, active-low, asynchronous.
- ide_diow  in  1  write strobe, active-low, asynchronous.
- ide_cs  in  2  chip selects; addr = {ide_cs, ide_da}.
- ide_da  in  3  register address.
- mem_addr  out  MEM_AW  backing-store word address.
- mem_wdata  out  DATA_W  store write data.
- mem_rdata  in  DATA_W  store read data, valid in the mem_ack cycle.
- mem_we  out  1  1 = write, 0 = read; qualified by mem_req.
- mem_req  out  1  request; held until mem_ack.
- mem_ack  in  1  one word transferred this cycle.

Behaviour:
- Strobes:
  - ide_dior and ide_diow each pass through a 2-flop synchroniser plus an edge register.
  - An action occurs in the single cycle its falling edge is detected. Latency from the pin to the action is 3 clk.
  - ide_da, ide_cs and ide_data_in are sampled in that same cycle.
  - ide_data_out loads on the dior falling edge and returns to 0 on the dior rising edge.
- Register map:
  - 0x10 DATA.
  - 0x11 ERROR (read) / FEATURE (write, ignored).
  - 0x12 SECCNT, 0x13 SECNUM, 0x14 CYLLOW, 0x15 CYLHIGH, 0x16 DRVHEAD: 8-bit, read/write.
  - 0x17 STATUS (read) / COMMAND (write).
  - 0x0e ALTSTATUS (read).
  - 0x1e DEVCTRL (write).
  - Unmapped reads return 0. Register reads zero-extend to DATA_W.
- Reset values:
  - status = 0x50 (DRDY|DSC), error = 0, taskfile registers = 0.
  - FSM = IDLE, buffer pointer = 0, ide_data_out = 0, mem_req = 0, mem_we = 0.
- Starting LBA = {drvhead[3:0], cylhigh, cyllow, secnum}, zero-extended to LBA_W. Sector count = seccnt, where 0 means 256.
- The store address for the current word is lba*SECTOR_WORDS + ptr.
- FSM:
  - IDLE:
    - Command 0x20 (READ): status = BSY|DRDY|DSC (0xD0), go to RD_FETCH.
    - Command 0x30 (WRITE): status = 0x58 (DRQ), go to WR_XFER.
    - Any other command: status = 0x51 (ERR), error = 0x04 (ABRT), stay in IDLE.
    - A valid command clears ERR and the error register.
  - RD_FETCH:
    - Issue SECTOR_WORDS read requests into the buffer, one word per ack.
    - Then ptr = 0, status = 0x58, go to RD_XFER.
  - RD_XFER:
    - Each DATA read returns buf[ptr], then ptr++.
    - After the last word: decrement remaining, lba++.
    - If remaining > 0: status = 0xD0, go to RD_FETCH. Otherwise status = 0x50, go to IDLE.
  - WR_XFER:
    - Each DATA write stores buf[ptr], then ptr++.
    - After the last word: status = 0xD0, go to WR_FLUSH.
  - WR_FLUSH:
    - Issue SECTOR_WORDS write requests with mem_we = 1.
    - Then lba++, remaining--.
    - If remaining > 0: status = 0x58, go to WR_XFER. Otherwise status = 0x50, go to IDLE.
- DATA access outside the XFER states:
  - A read returns 0; ptr does not change.
  - A write is ignored.
- COMMAND writes while not in IDLE are ignored. Taskfile writes while BSY are ignored.
- DEVCTRL write with bit2 (SRST) = 1:
  - In any state, abort on the next cycle and go to IDLE with status 0x50, error 0.
  - mem_req drops immediately, even if ack is outstanding; a later stray ack is ignored.
- mem_req may be asserted back-to-back. mem_addr and mem_wdata are stable while mem_req=1 and no ack has been received.
- LBA wraps modulo 2^LBA_W. Taskfile registers do not change during a transfer.
- If a strobe edge and mem_ack occur in the same cycle, both are processed.

Test Plan:
- Reset, then read STATUS (0x17) → 0x0050; read ERROR → 0x0000; mem_req = 0.
- Set secnum=5, cyl=0, drvhead=0xE0, seccnt=1, store word[1280+k] = k; command 0x20 → status 0xD0 during the fetch; mem_addr 1280..1535. Status then 0x58; 256 DATA reads return 0..255; status then 0x50.
- seccnt=2, command 0x30, write 512 words 0xA000+i → two flushes; mem_addr lba*256.. and (lba+1)*256..; status 0x58 between sectors; ends at 0x50.
- Command 0xEC → status 0x51, error 0x04; then a valid 0x20 → ERR cleared.
- Mid-RD_FETCH, write DEVCTRL=0x04 → mem_req = 0 next cycle; status 0x50; a subsequent DATA read returns 0.
- seccnt=0 READ at LBA 2^28−1 → 256 sectors fetched, the second at LBA 0; 65536 DATA reads before status returns to 0x50.
